// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_t : controller FSM states (IDLE / RUN / DONE)
//   OP_ADD  : operation select value for A + B + CIN
//   OP_SUB  : operation select value for A - B (computed as A + ~B + 1)
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder1.sv
// Single-bit full adder, the only arithmetic element of the serial adder.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One full adder is reused over WIDTH
// clocks, LSB first, with valid/ready handshakes on operand and result sides.
//   clk, rst_n                : clock (rising edge), async active-low reset
//   start_valid / start_ready : operand handshake; a_in, b_in, cin, op sampled
//                               on the accepting edge (op: 0 add, 1 subtract)
//   result_valid/result_ready : result handshake
//   sum_out, cout, ovf        : result, carry out of MSB (1 = no borrow on
//                               subtract), signed overflow; held until the
//                               next operation completes
//   busy                      : high while in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             op,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, work_sum;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  full_adder1 u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_n = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_n = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      work_sum <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            // Subtract reuses the adder as A + ~B + 1: invert B, seed carry.
            a_sh    <= a_in;
            b_sh    <= (op == OP_SUB) ? ~b_in : b_in;
            carry_q <= (op == OP_SUB) ? 1'b1 : cin;
            cnt     <= '0;
          end
        end
        ST_RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          work_sum <= {fa_sum, work_sum[WIDTH-1:1]};
          carry_q  <= fa_carry;
          if (last_bit) begin
            // carry_q here is the carry into the MSB; overflow is the
            // disagreement between carry into and out of the sign bit.
            sum_out <= {fa_sum, work_sum[WIDTH-1:1]};
            cout    <= fa_carry;
            ovf     <= carry_q ^ fa_carry;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         cin = 1'b0, op = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] sum_out;
  logic         cout, ovf, busy;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .op(op),
    .result_valid(result_valid), .result_ready(result_ready),
    .sum_out(sum_out), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = -1;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model from plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic o);
    exp_t   e;
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[W-1]) ? ua - (64'sd1 <<< W) : ua;
    sb = (b[W-1]) ? ub - (64'sd1 <<< W) : ub;
    if (o) begin
      ures = ua - ub;
      sres = sa - sb;
      e.c  = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(ci);
      sres = sa + sb + longint'(ci);
      e.c  = (ures >= (64'sd1 <<< W));
    end
    e.s   = W'(ures);
    e.o   = (sres > ((64'sd1 <<< (W - 1)) - 1)) || (sres < -(64'sd1 <<< (W - 1)));
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare the queue head whenever a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: result_valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          if (!prev_v) chk("latency", cyc - exp_q[0].acc, W);
          chk("sum_out", sum_out, exp_q[0].s);
          chk("cout", cout, exp_q[0].c);
          chk("ovf", ovf, exp_q[0].o);
        end
      end
      prev_v = result_valid;
    end
  end

  always @(posedge clk) begin
    if (rst_n && result_valid && result_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic o);
    exp_t e;
    @(negedge clk);
    #1;
    a_in = a; b_in = b; cin = ci; op = o;
    start_valid = 1'b1;
    chk("start_ready_idle", start_ready, 1);
    if (last_acc >= 0) chk("accept_spacing_ok", ((cyc + 1 - last_acc) >= W + 1), 1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
    e = model(a, b, ci, o);
    e.acc = cyc;
    exp_q.push_back(e);
    last_acc = cyc;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic o, input int hold);
    int n;
    result_ready = (hold == 0);
    accept(a, b, ci, o);
    @(negedge clk);
    chk("start_ready_run", start_ready, 0);
    chk("busy_run", busy, 1);
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      total++;
      bad++;
      $display("FAIL result_timeout: result_valid=0 required 1 after %0d cycles", n);
      finish_now();
    end
    #1;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom);
      a_in = W'($urandom);
      @(negedge clk);
      #1;
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_dropped", result_valid, 0);
    chk("ready_after_done", start_ready, 1);
    #1;
    result_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    #1 rst_n = 1'b1;

    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 1);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 2);
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 0);
    do_op(8'hC3, 8'h5A, 1'b0, 1'b0, 5);

    // Abort a running operation with reset after three RUN edges.
    accept(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_start_ready", start_ready, 1);
    chk("abort_result_valid", result_valid, 0);
    chk("abort_sum_out", sum_out, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    last_acc = -1;
    repeat (12) @(negedge clk);
    chk("post_abort_ready", start_ready, 1);
    chk("post_abort_valid", result_valid, 0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

    for (int k = 0; k < 30; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

    chk("queue_drained", exp_q.size(), 0);
    finish_now();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
